loopback_interceptor: RTL and testbench
=======================================

LOOPBACK_INTERCEPTOR -- requirements
Module: loopback_interceptor

Interface
REQ-001 SHALL have parameter LOOPBACK_DEPTH, default 2, meaning the number of entries in the loopback FIFO (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port local_address, input, 32, this node's bus address; held stable while out of reset.
REQ-005 SHALL have port send_loopback_valid, input, 1, upstream send request valid.
REQ-006 SHALL have port loopback_send_ready, output, 1, send request accepted.
REQ-007 SHALL have port send_loopback_data, input, interface_send_data_t, the outgoing message (meta.address is the destination).
REQ-008 SHALL have port loopback_interface_valid, output, 1, remote send valid to the bus communication interface.
REQ-009 SHALL have port interface_loopback_ready, input, 1, the interface accepts the send.
REQ-010 SHALL have port loopback_interface_data, output, interface_send_data_t, the forwarded message.
REQ-011 SHALL have port interface_loopback_valid, input, 1, message received from the bus is valid.
REQ-012 SHALL have port loopback_interface_ready, output, 1, bus-received message accepted.
REQ-013 SHALL have port interface_loopback_data, input, interface_receive_data_t, the bus-received message (meta.address is the source).
REQ-014 SHALL have port loopback_receive_valid, output, 1, received message valid to downstream.
REQ-015 SHALL have port receive_loopback_ready, input, 1, downstream accepts.
REQ-016 SHALL have port loopback_receive_data, output, interface_receive_data_t, the delivered message.

Function
REQ-017 SHALL classify a send as local when send_loopback_data.message.meta.address equals local_address over all 32 bits, and as remote otherwise.
REQ-018 SHALL pass remote sends combinationally to the interface: loopback_interface_valid = send_valid & remote; data unmodified; loopback_send_ready = interface_loopback_ready when the send is remote.
REQ-019 SHALL hold loopback_interface_valid at 0 whenever the send is local.
REQ-020 SHALL push a local send into the loopback FIFO, with loopback_send_ready = !full | pop_this_cycle.
REQ-021 SHALL convert each pushed entry to interface_receive_data_t: meta.address = local_address, meta.tag and data copied unchanged.
REQ-022 SHALL deliver the FIFO head after one cycle at minimum: a local send accepted in cycle N is earliest visible on loopback_receive_valid in N+1.
REQ-023 SHALL arbitrate the receive output between the FIFO head (L) and the bus-received message (B); when only one is valid, that one is granted.
REQ-024 SHALL, when L and B are both valid, grant the source not granted at the last completed transfer (round-robin); the last_grant register updates only when receive_loopback_valid & receive_loopback_ready.
REQ-025 SHALL drive loopback_receive_valid = L_valid | B_valid, with loopback_receive_data taken from the granted source.
REQ-026 SHALL drive loopback_interface_ready = receive_loopback_ready & grant==B, and pop the FIFO only when receive_loopback_ready & grant==L.
REQ-027 SHALL keep the grant stable while the output is valid and not accepted, provided the input valids do not change.
REQ-028 SHALL track occupancy in a counter of log2(LOOPBACK_DEPTH)+1 bits; a simultaneous push and pop leaves it unchanged, and the read/write pointers wrap modulo LOOPBACK_DEPTH.
REQ-029 SHALL never overflow (no push when full without a pop) or underflow (no pop when empty).

Reset
REQ-030 SHALL reset asynchronously on rst_n low: FIFO empty, pointers 0, occupancy 0, last_grant = B (so L wins the first conflict), FIFO data 0.
REQ-031 SHALL, during and directly after reset, drive loopback_receive_valid and loopback_send_ready only from the reset state and the inputs, with no stale FIFO entries; any in-flight FIFO contents are discarded.

Structure
REQ-032 SHALL use interface_send_data_t and interface_receive_data_t from xctcmsg_pkg; no new package types are required.
REQ-033 SHALL place the loopback FIFO in one sub-module, loopback_fifo (parameterised depth, valid/ready push and pop).

Verification
REQ-034 SHALL cover remote send: local_address=5, dst=9, tag=3, data=0xAA, interface_ready=1 -> same cycle loopback_interface_valid=1 with identical data, FIFO stays empty.
REQ-035 SHALL cover local send: dst=5, tag=7, data=0x1234, receive_ready=1 -> next cycle loopback_receive_valid=1 with address=5, tag=7, data=0x1234.
REQ-036 SHALL cover full FIFO: receive_ready=0, three local sends -> two accepted, third has loopback_send_ready=0; raising receive_ready allows push and pop in the same cycle.
REQ-037 SHALL cover contention: L and B valid continuously, receive_ready=1 after reset -> grant order L,B,L,B, and loopback_interface_ready is high only on the B cycles.
REQ-038 SHALL cover backpressure: B valid, receive_ready=0 for 3 cycles -> loopback_interface_ready=0 and the output is stable; then delivered once.
REQ-039 SHALL cover reset mid-operation: FIFO holding 1 entry, rst_n pulsed low -> loopback_receive_valid=0 immediately and the FIFO is empty after reset.

Source files
------------

// File: rtl/loopback_interceptor_pkg.sv
// Message types shared with the bus communication interface (xctcmsg_pkg)
// and the loopback interceptor's local helpers (loopback_interceptor_pkg).
//   xctcmsg_pkg             : send/receive message structs (meta.address + tag, data)
//   loopback_interceptor_pkg: receive-arbiter grant enum, send->receive conversion
package xctcmsg_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [7:0]  tag;
  } msg_meta_t;

  typedef struct packed {
    msg_meta_t   meta;
    logic [31:0] data;
  } msg_t;

  // meta.address is the destination on send, the source on receive
  typedef struct packed { msg_t message; } interface_send_data_t;
  typedef struct packed { msg_t message; } interface_receive_data_t;
endpackage

package loopback_interceptor_pkg;
  import xctcmsg_pkg::*;

  typedef enum logic { GRANT_L = 1'b0, GRANT_B = 1'b1 } grant_e;

  // A looped-back message arrives "from" this node, so the source address
  // is our own address; tag and payload pass through untouched.
  function automatic interface_receive_data_t to_receive(
    input interface_send_data_t s, input logic [31:0] local_addr);
    interface_receive_data_t r;
    r.message.meta.address = local_addr;
    r.message.meta.tag     = s.message.meta.tag;
    r.message.data         = s.message.data;
    return r;
  endfunction
endpackage

// File: rtl/loopback_interceptor_if.sv
// Bundle of every handshake/bus signal of loopback_interceptor.
//   master : the environment side (drives requests, readies, bus-received data)
//   slave  : the interceptor side
interface loopback_interceptor_if;
  import xctcmsg_pkg::*;
  logic [31:0]             local_address;
  logic                    send_loopback_valid;
  logic                    loopback_send_ready;
  interface_send_data_t    send_loopback_data;
  logic                    loopback_interface_valid;
  logic                    interface_loopback_ready;
  interface_send_data_t    loopback_interface_data;
  logic                    interface_loopback_valid;
  logic                    loopback_interface_ready;
  interface_receive_data_t interface_loopback_data;
  logic                    loopback_receive_valid;
  logic                    receive_loopback_ready;
  interface_receive_data_t loopback_receive_data;

  modport master (
    output local_address, send_loopback_valid, send_loopback_data,
           interface_loopback_ready, interface_loopback_valid,
           interface_loopback_data, receive_loopback_ready,
    input  loopback_send_ready, loopback_interface_valid, loopback_interface_data,
           loopback_interface_ready, loopback_receive_valid, loopback_receive_data
  );
  modport slave (
    input  local_address, send_loopback_valid, send_loopback_data,
           interface_loopback_ready, interface_loopback_valid,
           interface_loopback_data, receive_loopback_ready,
    output loopback_send_ready, loopback_interface_valid, loopback_interface_data,
           loopback_interface_ready, loopback_receive_valid, loopback_receive_data
  );
endinterface

// File: rtl/loopback_fifo.sv
// Loopback FIFO: DEPTH entries (power of two), valid/ready on both ends.
//   push_valid_i/push_ready_o/push_data_i : write side; ready when not full
//                                           or when the head leaves this cycle
//   pop_valid_o/pop_ready_i/pop_data_o    : read side; head is registered,
//                                           so a push is visible next cycle
module loopback_fifo
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  interface_receive_data_t push_data_i,
  output logic                    pop_valid_o,
  input  logic                    pop_ready_i,
  output interface_receive_data_t pop_data_o
);
  localparam int AW = $clog2(DEPTH);

  interface_receive_data_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, push_fire, pop_fire;

  assign full         = (count_q == (AW+1)'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign pop_fire     = pop_valid_o & pop_ready_i;
  assign push_ready_o = ~full | pop_fire;
  assign push_fire    = push_valid_i & push_ready_o;

  always_comb begin
    count_d = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

// File: rtl/loopback_interceptor.sv
// Loopback interceptor: sends addressed to this node are turned around
// through a small FIFO instead of going out on the bus, and merged with
// bus-received traffic onto a single receive stream.
//   clk, rst_n                         : clock, async active-low reset
//   local_address                      : this node's address
//   send_loopback_* / loopback_send_*  : upstream send request
//   loopback_interface_* / interface_loopback_ready : remote send to bus
//   interface_loopback_* / loopback_interface_ready : message from bus
//   loopback_receive_* / receive_loopback_ready     : merged receive stream
module loopback_interceptor
  import xctcmsg_pkg::*;
  import loopback_interceptor_pkg::*;
#(
  parameter int LOOPBACK_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             local_address,
  input  logic                    send_loopback_valid,
  output logic                    loopback_send_ready,
  input  interface_send_data_t    send_loopback_data,
  output logic                    loopback_interface_valid,
  input  logic                    interface_loopback_ready,
  output interface_send_data_t    loopback_interface_data,
  input  logic                    interface_loopback_valid,
  output logic                    loopback_interface_ready,
  input  interface_receive_data_t interface_loopback_data,
  output logic                    loopback_receive_valid,
  input  logic                    receive_loopback_ready,
  output interface_receive_data_t loopback_receive_data
);
  logic                    is_local;
  logic                    l_valid, l_ready, push_ready;
  interface_receive_data_t l_data;
  grant_e                  grant, last_grant_q, last_grant_d;

  assign is_local = (send_loopback_data.message.meta.address == local_address);

  // Remote path is pure wiring; a local send never reaches the bus.
  assign loopback_interface_valid = send_loopback_valid & ~is_local;
  assign loopback_interface_data  = send_loopback_data;
  assign loopback_send_ready      = is_local ? push_ready : interface_loopback_ready;

  loopback_fifo #(.DEPTH(LOOPBACK_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (send_loopback_valid & is_local),
    .push_ready_o (push_ready),
    .push_data_i  (to_receive(send_loopback_data, local_address)),
    .pop_valid_o  (l_valid),
    .pop_ready_i  (l_ready),
    .pop_data_o   (l_data)
  );

  // Round-robin between FIFO head (L) and bus (B). The grant is a function
  // of the valids and last_grant_q only, so it cannot move under backpressure.
  always_comb begin
    grant        = GRANT_B;
    last_grant_d = last_grant_q;
    if (l_valid && (!interface_loopback_valid || last_grant_q == GRANT_B))
      grant = GRANT_L;
    if (loopback_receive_valid && receive_loopback_ready)
      last_grant_d = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GRANT_B;
    else        last_grant_q <= last_grant_d;
  end

  assign loopback_receive_valid   = l_valid | interface_loopback_valid;
  assign loopback_receive_data    = (grant == GRANT_L) ? l_data : interface_loopback_data;
  assign loopback_interface_ready = receive_loopback_ready & (grant == GRANT_B);
  assign l_ready                  = receive_loopback_ready & (grant == GRANT_L);
endmodule

// File: tb/tb_loopback_interceptor.sv
module tb_loopback_interceptor;
  import xctcmsg_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  loopback_interceptor_if bus();

  loopback_interceptor #(.LOOPBACK_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .local_address            (bus.local_address),
    .send_loopback_valid      (bus.send_loopback_valid),
    .loopback_send_ready      (bus.loopback_send_ready),
    .send_loopback_data       (bus.send_loopback_data),
    .loopback_interface_valid (bus.loopback_interface_valid),
    .interface_loopback_ready (bus.interface_loopback_ready),
    .loopback_interface_data  (bus.loopback_interface_data),
    .interface_loopback_valid (bus.interface_loopback_valid),
    .loopback_interface_ready (bus.loopback_interface_ready),
    .interface_loopback_data  (bus.interface_loopback_data),
    .loopback_receive_valid   (bus.loopback_receive_valid),
    .receive_loopback_ready   (bus.receive_loopback_ready),
    .loopback_receive_data    (bus.loopback_receive_data)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: loopback queue of delivered-form messages, and which
  // source won the last completed receive transfer.
  logic [71:0] q[$];
  bit          last_was_b;
  logic [31:0] laddr;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic interface_send_data_t mk_send(input logic [31:0] a, input logic [7:0] t,
                                                   input logic [31:0] d);
    interface_send_data_t s;
    s.message.meta.address = a;
    s.message.meta.tag     = t;
    s.message.data         = d;
    return s;
  endfunction

  function automatic interface_receive_data_t mk_recv(input logic [31:0] a, input logic [7:0] t,
                                                      input logic [31:0] d);
    interface_receive_data_t r;
    r.message.meta.address = a;
    r.message.meta.tag     = t;
    r.message.data         = d;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs against
  // the model, advance the model across the posedge.
  task automatic step(input logic sv, input interface_send_data_t sd, input logic ir,
                      input logic bv, input interface_receive_data_t bd, input logic rr);
    bit          loc, lv, gl, pop, sready, rv;
    logic [71:0] exp_rd;
    bus.send_loopback_valid      = sv;
    bus.send_loopback_data       = sd;
    bus.interface_loopback_ready = ir;
    bus.interface_loopback_valid = bv;
    bus.interface_loopback_data  = bd;
    bus.receive_loopback_ready   = rr;
    #1;
    loc    = (sd.message.meta.address == laddr);
    lv     = (q.size() > 0);
    gl     = lv && (!bv || last_was_b);
    rv     = lv || bv;
    exp_rd = gl ? q[0] : 72'(bd);
    pop    = rr && gl;
    sready = loc ? ((q.size() < DEPTH) || pop) : ir;
    chk("if_valid", 128'(bus.loopback_interface_valid), 128'(sv && !loc));
    if (sv && !loc) chk("if_data", 128'(bus.loopback_interface_data), 128'(sd));
    chk("send_ready", 128'(bus.loopback_send_ready), 128'(sready));
    chk("rx_valid", 128'(bus.loopback_receive_valid), 128'(rv));
    if (rv) chk("rx_data", 128'(bus.loopback_receive_data), 128'(exp_rd));
    chk("if_ready", 128'(bus.loopback_interface_ready), 128'(rr && !gl));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (sv && loc && sready)
      q.push_back({laddr, sd.message.meta.tag, sd.message.data});
    if (rv && rr) last_was_b = !gl;
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, 1'b0, 1'b0, '0, rr);
  endtask

  // Reset pulse landing between clock edges; a local send is held valid so
  // send_ready during reset reflects an empty FIFO.
  task automatic do_reset(input logic [31:0] addr);
    bus.interface_loopback_valid = 1'b0;
    bus.receive_loopback_ready   = 1'b0;
    bus.send_loopback_valid      = 1'b1;
    bus.send_loopback_data       = mk_send(laddr, 8'h1, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rx_valid", 128'(bus.loopback_receive_valid), 128'(0));
    chk("rst_send_ready", 128'(bus.loopback_send_ready), 128'(1));
    q.delete();
    last_was_b = 1'b1;
    @(negedge clk);
    laddr = addr;
    bus.local_address       = addr;
    bus.send_loopback_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    laddr = 32'd5;
    bus.local_address = laddr;
    bus.send_loopback_valid = 1'b0;
    bus.send_loopback_data = '0;
    bus.interface_loopback_ready = 1'b0;
    bus.interface_loopback_valid = 1'b0;
    bus.interface_loopback_data = '0;
    bus.receive_loopback_ready = 1'b0;
    last_was_b = 1'b1;
    @(negedge clk);
    do_reset(32'd5);

    // Remote send passes straight through; FIFO stays empty.
    step(1'b1, mk_send(32'd9, 8'd3, 32'hAA), 1'b1, 1'b0, '0, 1'b1);
    idle(1'b1);

    // Local send appears on the receive side the next cycle.
    step(1'b1, mk_send(32'd5, 8'd7, 32'h1234), 1'b1, 1'b0, '0, 1'b1);
    chk("loc_rx_valid", 128'(bus.loopback_receive_valid), 128'(1));
    chk("loc_rx_data", 128'(bus.loopback_receive_data), 128'(mk_recv(32'd5, 8'd7, 32'h1234)));
    idle(1'b1);

    // Full FIFO: third local send refused, then push+pop in one cycle.
    for (int i = 0; i < 3; i++)
      step(1'b1, mk_send(32'd5, 8'(i), 32'h100 + i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, mk_send(32'd5, 8'd2, 32'h102), 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Contention after reset: L and B alternate.
    do_reset(32'd5);
    step(1'b1, mk_send(32'd5, 8'h10, 32'h0), 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, mk_send(32'd5, 8'h20 + 8'(i), 32'(i)), 1'b0, 1'b1,
           mk_recv(32'h77, 8'(i), 32'hB0 + 32'(i)), 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Bus backpressure: held for three cycles, then delivered once.
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, 1'b0, 1'b1, mk_recv(32'h33, 8'h44, 32'hCAFE), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, mk_recv(32'h33, 8'h44, 32'hCAFE), 1'b1);
    idle(1'b1);

    // Reset with one entry in flight; FIFO must come back empty.
    step(1'b1, mk_send(32'd5, 8'h55, 32'h5555), 1'b0, 1'b0, '0, 1'b0);
    do_reset(32'd5);
    idle(1'b1);

    // Randomised traffic with a fresh random local address.
    do_reset($urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(1, 0) == 1) ? laddr : $urandom;
      if (a == laddr && $urandom_range(1, 0) == 0) a = laddr ^ 32'h1;
      step($urandom_range(99, 0) < 60, mk_send(a, 8'($urandom), $urandom),
           $urandom_range(99, 0) < 70,
           $urandom_range(99, 0) < 50, mk_recv($urandom, 8'($urandom), $urandom),
           $urandom_range(99, 0) < 55);
      if (i == 1500) do_reset($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
